// File: rtl/gpr_port_ctrl_pkg.sv
// Shared sizing, writeback entry type and one-hot decode used by the GPR
// port controller, its writeback FIFO and the GPR array.
package gpr_port_ctrl_pkg;

  localparam int NREG      = 32;
  localparam int IDX_W     = 5;
  localparam int DW        = 32;
  localparam int WBQ_DEPTH = 2;

  typedef struct packed {
    logic [IDX_W-1:0] rd;
    logic [DW-1:0]    data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREG-1:0] vec;
    vec      = {NREG{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO that buffers execute results until the GPR write
// port is free. The head entry is visible before it is popped.
module gpr_wb_fifo
  import gpr_port_ctrl_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/gpr_port_ctrl.sv
// GPR port controller: busy scoreboard, writeback buffering, one-hot
// read/write enables and bus-C bypass selection for operands.
module gpr_port_ctrl
  import gpr_port_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [IDX_W-1:0] iss_rs1,
  input  logic [IDX_W-1:0] iss_rs2,
  input  logic [IDX_W-1:0] iss_rd,
  input  logic             iss_rd_we,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [IDX_W-1:0] wb_rd,
  input  logic [DW-1:0]    wb_data,
  output logic [NREG-1:0]  rd_A_en,
  output logic [NREG-1:0]  rd_B_en,
  output logic [NREG-1:0]  wt_en,
  output logic [NREG-1:0]  through_C_en,
  output logic [DW-1:0]    data_in,
  output logic             opnd_valid,
  output logic             sel_A_c,
  output logic             sel_B_c,
  output logic             sb_err
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  wb_entry_t       head;
  wb_entry_t       push_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            ok_a;
  logic            ok_b;
  logic            waw_ok;
  logic            accept;
  logic            byp_a;
  logic            byp_b;

  assign pop        = !fifo_empty;
  assign wb_ready   = !fifo_full;
  assign push       = wb_valid & wb_ready;
  assign push_entry = '{rd: wb_rd, data: wb_data};

  gpr_wb_fifo #(.DEPTH(WBQ_DEPTH)) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Hazard check and scoreboard update; the head being written this cycle is
  // the final value for its register, so a matching source may use bus C.
  always_comb begin
    ok_a      = (iss_rs1 == '0) || !busy[iss_rs1] || (pop && head.rd == iss_rs1);
    ok_b      = (iss_rs2 == '0) || !busy[iss_rs2] || (pop && head.rd == iss_rs2);
    waw_ok    = !iss_rd_we || (iss_rd == '0) || !busy[iss_rd];
    iss_ready = ok_a & ok_b & waw_ok;
    accept    = iss_valid & iss_ready;
    byp_a     = pop && (iss_rs1 != '0) && (head.rd == iss_rs1);
    byp_b     = pop && (iss_rs2 != '0) && (head.rd == iss_rs2);
    busy_next = busy;
    if (pop) busy_next[head.rd] = 1'b0;
    else     busy_next = busy_next;
    if (accept && iss_rd_we && iss_rd != '0) busy_next[iss_rd] = 1'b1;
    else                                      busy_next = busy_next;
    busy_next[0] = 1'b0;
  end

  // Registered port outputs and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      sb_err       <= 1'b0;
      wt_en        <= '0;
      through_C_en <= '0;
      data_in      <= '0;
      opnd_valid   <= 1'b0;
      sel_A_c      <= 1'b0;
      sel_B_c      <= 1'b0;
      rd_A_en      <= '0;
      rd_B_en      <= '0;
    end else begin
      busy         <= busy_next;
      sb_err       <= sb_err | (push && wb_rd != '0 && !busy[wb_rd]);
      wt_en        <= (pop && head.rd != '0) ? onehot(head.rd) : '0;
      through_C_en <= (pop && head.rd != '0) ? onehot(head.rd) : '0;
      data_in      <= pop ? head.data : '0;
      opnd_valid   <= accept;
      sel_A_c      <= accept & byp_a;
      sel_B_c      <= accept & byp_b;
      rd_A_en      <= (accept && !byp_a) ? onehot(iss_rs1) : '0;
      rd_B_en      <= (accept && !byp_b) ? onehot(iss_rs2) : '0;
    end
  end

endmodule
